// File: rtl/spi_target_controller_pkg.sv
// rtl/spi_target_controller_pkg.sv - register map, status bits and FSM encoding for the SPI target
package spi_target_controller_pkg;

  localparam logic [1:0] REG_RXDATA = 2'd0;
  localparam logic [1:0] REG_TXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int STAT_RX_VALID   = 0;
  localparam int STAT_RX_OVERRUN = 1;
  localparam int STAT_TX_FULL    = 2;
  localparam int STAT_SS_ACTIVE  = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_target_controller_sync_edge.sv
// rtl/spi_target_controller_sync_edge.sv - 2-FF synchronizer with registered edge detect
module spi_sync_edge (
  input  logic clk,
  input  logic raw,
  output logic sync,
  output logic rise,
  output logic fall
);

  // Left unreset so that an input held steady through reset never produces a false edge.
  logic [2:0] pipe;

  always_ff @(posedge clk) begin
    pipe <= {pipe[1:0], raw};
  end

  assign sync = pipe[1];
  assign rise = pipe[1] & ~pipe[2];
  assign fall = ~pipe[1] & pipe[2];

endmodule

// File: rtl/spi_target_controller.sv
// rtl/spi_target_controller.sv - SPI mode-0 target with a four-word CPU register window
module spi_target_controller
  import spi_target_controller_pkg::*;
#(
  parameter logic [31:0] ADDRESS   = 32'h7000_0000,
  parameter logic [7:0]  IDLE_FILL = 8'hFF
) (
  input  logic        cpu_clk,
  input  logic        rst,
  inout  wire  [31:0] data_bus,
  input  logic [29:0] data_address,
  input  logic        data_cs,
  input  logic        data_rw,
  input  logic        spi_clk_i,
  input  logic        spi_ss_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o
);

  logic       sclk_sync, sclk_rise, sclk_fall;
  logic       ss_sync, ss_rise, ss_fall;
  logic [1:0] mosi_pipe;
  logic       mosi;

  spi_sync_edge u_sclk (
    .clk  (cpu_clk),
    .raw  (spi_clk_i),
    .sync (sclk_sync),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge u_ss (
    .clk  (cpu_clk),
    .raw  (spi_ss_i),
    .sync (ss_sync),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  // MOSI gets the same two-stage delay as SCLK so it lines up with the rise pulse.
  always_ff @(posedge cpu_clk) begin
    mosi_pipe <= {mosi_pipe[0], spi_mosi_i};
  end
  assign mosi = mosi_pipe[1];

  logic        hit, rd_en, wr_en, pop, tx_wr, ctrl_clear;
  logic [1:0]  reg_sel;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign hit        = (data_address[29:2] == ADDRESS[31:4]);
  assign reg_sel    = data_address[1:0];
  assign rd_en      = data_cs & data_rw & hit;
  assign wr_en      = data_cs & ~data_rw & hit;
  assign pop        = rd_en && (reg_sel == REG_RXDATA);
  assign tx_wr      = wr_en && (reg_sel == REG_TXDATA);
  assign ctrl_clear = wr_en && (reg_sel == REG_CTRL) && data_bus[0];
  assign unused_bits = ^{data_bus[31:8], sclk_sync, ss_sync};

  spi_state_t state, state_next;
  logic       load_shift;
  logic [7:0] shift_in, shift_out, rx_data, tx_buf;
  logic [2:0] bit_cnt;
  logic       reload_pend, commit, rx_valid, rx_overrun, tx_full, ss_active;

  assign ss_active = (state == ST_ACTIVE);

  always_ff @(posedge cpu_clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_shift = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ss_fall) begin
          state_next = ST_ACTIVE;
          load_shift = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (ss_rise)                        state_next = ST_IDLE;
        else if (sclk_fall && reload_pend)  load_shift = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      shift_in    <= '0;
      shift_out   <= '0;
      bit_cnt     <= '0;
      reload_pend <= 1'b0;
      commit      <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_buf      <= '0;
      tx_full     <= 1'b0;
    end else begin
      commit <= 1'b0;

      if (load_shift) begin
        shift_out   <= tx_full ? tx_buf : IDLE_FILL;
        reload_pend <= 1'b0;
      end else if (ss_active && !ss_rise && sclk_fall) begin
        shift_out <= {shift_out[6:0], 1'b0};
      end

      if (!ss_active) begin
        bit_cnt <= '0;
      end else if (ss_rise) begin
        bit_cnt     <= '0;
        reload_pend <= 1'b0;
      end else if (sclk_rise) begin
        shift_in <= {shift_in[6:0], mosi};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          commit      <= 1'b1;
          reload_pend <= 1'b1;
        end
      end

      // Commit one cycle after the last shift; a same-cycle pop frees the slot for the new byte.
      if (ctrl_clear) rx_overrun <= 1'b0;
      if (commit) begin
        if (rx_valid && !pop) begin
          rx_overrun <= 1'b1;
        end else begin
          rx_data  <= shift_in;
          rx_valid <= 1'b1;
        end
      end else if (pop) begin
        rx_valid <= 1'b0;
      end

      if (tx_wr) begin
        tx_buf  <= data_bus[7:0];
        tx_full <= 1'b1;
      end else if (load_shift) begin
        tx_full <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_RXDATA: rd_data[7:0] = rx_data;
      REG_STATUS: begin
        rd_data[STAT_RX_VALID]   = rx_valid;
        rd_data[STAT_RX_OVERRUN] = rx_overrun;
        rd_data[STAT_TX_FULL]    = tx_full;
        rd_data[STAT_SS_ACTIVE]  = ss_active;
      end
      default: rd_data = '0;
    endcase
  end

  assign data_bus   = rd_en ? rd_data : 32'bz;
  assign spi_miso_o = ss_active ? shift_out[7] : 1'b1;

endmodule
